forward_unit: RTL and testbench
===============================

// Module: forward_unit
// PURPOSE
// - Issue-side hazard/forwarding producer for the EX-stage ALU; drives the ALU's forward, need_forward inputs.
// - Tracks destinations of the two instructions ahead of ID (EX, MEM), selects one forward source, stalls ID on load-use or split-source hazards.
// - Sits between decode and the ID/EX register; x0 is never forwarded.
// PARAMETERS
// - XLEN     32  datapath width
// - REGBITS  5   register index width
// PORTS
// - clk          in   1        clock
// - reset        in   1        asynchronous, active-high reset
// - id_valid     in   1        instruction in ID is valid
// - id_opcode    in   7        opcode of ID instruction
// - id_rs1       in   REGBITS  source 1 index
// - id_rs2       in   REGBITS  source 2 index
// - id_rd        in   REGBITS  destination index
// - ex_result    in   XLEN     ALU registered rd output (result of instr issued last cycle)
// - wb_data      in   XLEN     MEM-stage result (ALU result or load data, one cycle older)
// - stall        out  1        hold PC/IF/ID, inject bubble into EX
// - need_forward out  2        [1]=rs1 from forward, [0]=rs2 from forward (registered)
// - forward      out  XLEN     forwarded operand (combinational mux of ex_result/wb_data)
// BEHAVIOUR
// - Consumers: R 0110011, B 1100011 use rs1+rs2; I 0010011, load 0000011, S 0100011, JALR 1100111 use rs1.
// - Writers (rd!=0): R, I, load, JAL 1101111, JALR, AUIPC 0010111, LUI 0110111. B, S never write.
// - Tracking regs: s1 {valid,rd,is_load} = instr now in EX; s2 {valid,rd,is_load} = instr now in MEM.
// - Each edge (no stall): s2<=s1; s1<=ID instr (valid = id_valid & writer & rd!=0). On stall: s2<=s1; s1<=bubble (valid=0).
// - Match: hit1_x = s1.valid & id_rsx==s1.rd & rsx used & rsx!=0; hit2_x likewise vs s2; s1 wins over s2.
// - Source per operand: S1 (ex_result) if hit1, S2 (wb_data) if hit2 only, NONE otherwise.
// - Load-use: any hit1 with s1.is_load -> stall (load data reaches wb_data next cycle via s2).
// - Split: rs1 and rs2 both forwarded from different sources -> stall 1 cycle (single forward bus).
// - stall is combinational from ID inputs and s1/s2; never asserted when id_valid=0.
// - On non-stall edge: need_forward<={src1!=NONE,src2!=NONE}; fsel<=S1/S2 (common source); stall edge -> need_forward<=2'b00.
// - forward = fsel==S1 ? ex_result : fsel==S2 ? wb_data : 0.
// - rs1==rs2 with one hit -> need_forward=2'b11, single source.
// - FSM (state reg): RUN -> LSTALL on load-use; RUN -> SSTALL on split; LSTALL/SSTALL -> RUN after 1 cycle
//   (re-evaluated; load in s2 now forwards via S2; split resolves as older writer retires to regfile).
// - Back-to-back load-use then split: LSTALL -> SSTALL permitted; max 2 consecutive stall cycles.
// - Reset (async, any state, mid-stall): state=RUN, s1/s2 valid=0, need_forward=2'b00, fsel=NONE, stall=0.
// - Latency: need_forward/fsel valid the cycle after issue, aligned with ALU operation.
// CONFIGURATION
// - FWD_STATS_EN defined: adds output stall_count [31:0], +1 each cycle stall=1, wraps at 2^32-1 -> 0, reset to 0.
// - FWD_STATS_EN undefined: no stall_count port, no counter logic; all other behaviour identical.
// TESTING
// - add x5,x1,x2 then add x6,x5,x3 -> no stall; next cycle need_forward=2'b10, forward=ex_result.
// - lw x7,0(x1) then addi x8,x7,1 -> stall=1 one cycle; addi issues with need_forward=2'b10, forward=wb_data.
// - add x5; add x9; add x10,x5,x9 -> stall 1 cycle (split); after stall need_forward=2'b01 from S2... x5 in regfile, x9 fwd.
// - add x0,x1,x2 then add x3,x0,x0 -> need_forward=2'b00, stall=0.
// - add x4,x1,x1 then add x5,x4,x4 -> need_forward=2'b11, forward=ex_result.
// - assert reset during LSTALL -> stall=0, need_forward=2'b00 immediately; stall_count=0 (FWD_STATS_EN).

Source files
------------

// File: rtl/forward_unit.sv
// forward_unit: EX-stage operand forwarding select and ID hazard stall generator (optional stall_count under FWD_STATS_EN)
module forward_unit #(
    parameter int XLEN    = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [6:0]         id_opcode,
    input  logic [REGBITS-1:0] id_rs1,
    input  logic [REGBITS-1:0] id_rs2,
    input  logic [REGBITS-1:0] id_rd,
    input  logic [XLEN-1:0]    ex_result,
    input  logic [XLEN-1:0]    wb_data,
    output logic               stall,
    output logic [1:0]         need_forward,
    output logic [XLEN-1:0]    forward
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]        stall_count
`endif
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_B = 7'b1100011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111;
    typedef enum logic [1:0] {RUN, LSTALL, SSTALL} state_t;
    typedef enum logic [1:0] {NONE, S1, S2} src_t;
    state_t state, state_nx;
    src_t fsel, src_a, src_b;
    logic s1_valid, s1_load, s2_valid, s2_load;
    logic [REGBITS-1:0] s1_rd, s2_rd;
    logic use_a, use_b, writer, hit1_a, hit1_b, hit2_a, hit2_b, load_use, split;
    // Decode the ID instruction, match its sources against EX/MEM writers, derive stall and next state
    always_comb begin
        use_a    = id_opcode inside {OP_R, OP_B, OP_I, OP_LD, OP_S, OP_JALR};
        use_b    = id_opcode inside {OP_R, OP_B};
        writer   = id_opcode inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
        hit1_a   = id_valid && use_a && id_rs1 != '0 && s1_valid && id_rs1 == s1_rd;
        hit1_b   = id_valid && use_b && id_rs2 != '0 && s1_valid && id_rs2 == s1_rd;
        hit2_a   = id_valid && use_a && id_rs1 != '0 && s2_valid && id_rs1 == s2_rd;
        hit2_b   = id_valid && use_b && id_rs2 != '0 && s2_valid && id_rs2 == s2_rd;
        src_a    = hit1_a ? S1 : hit2_a ? S2 : NONE;
        src_b    = hit1_b ? S1 : hit2_b ? S2 : NONE;
        load_use = s1_load && (hit1_a || hit1_b);
        split    = src_a != NONE && src_b != NONE && src_a != src_b;
        // after a split stall s1 is a bubble so nothing can hazard; after a load stall only a split remains possible
        stall    = state == SSTALL ? 1'b0 : state == LSTALL ? split : (load_use || split);
        state_nx = !stall ? RUN : (state == RUN && load_use) ? LSTALL : SSTALL;
        forward  = fsel == S1 ? ex_result : fsel == S2 ? wb_data : '0;
    end
    // Advance the EX/MEM destination trackers and register the forward selection for the ALU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            s1_valid     <= 1'b0;
            s1_load      <= 1'b0;
            s1_rd        <= '0;
            s2_valid     <= 1'b0;
            s2_load      <= 1'b0;
            s2_rd        <= '0;
            need_forward <= 2'b00;
            fsel         <= NONE;
        end else begin
            state        <= state_nx;
            s2_valid     <= s1_valid;
            s2_load      <= s1_load;
            s2_rd        <= s1_rd;
            s1_valid     <= !stall && id_valid && writer && id_rd != '0;
            s1_load      <= !stall && id_opcode == OP_LD;
            s1_rd        <= id_rd;
            need_forward <= stall ? 2'b00 : {src_a != NONE, src_b != NONE};
            fsel         <= stall ? NONE : src_a != NONE ? src_a : src_b;
        end
    end
`ifdef FWD_STATS_EN
    // Count every cycle spent stalling; wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_count <= '0;
        else if (stall) stall_count <= stall_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: randomized and directed checks of forward_unit against a pipeline-history model
module tb_forward_unit;
    localparam logic [6:0] OP_R = 7'b0110011, OP_B = 7'b1100011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LUI = 7'b0110111, OP_SYS = 7'b1110011;
    logic clk = 0, reset = 1, id_valid = 0, stall;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [31:0] ex_result = '0, wb_data = '0, forward;
    logic [1:0] need_forward;
`ifdef FWD_STATS_EN
    logic [31:0] stall_count;
`endif
    int n_vec = 0, n_bad = 0;
    bit hv [2];
    bit hl [2];
    int hrd [2];
    int m_fsel = 0, m_scount = 0;
    logic [1:0] m_nf = 2'b00;
    bit last_stall = 0;
    logic [6:0] l_op;
    logic [4:0] l_rd, l_a, l_b;
    logic [6:0] ops [10] = '{OP_R, OP_B, OP_I, OP_LD, OP_S, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI, OP_SYS};

    forward_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_result(ex_result), .wb_data(wb_data),
        .stall(stall), .need_forward(need_forward), .forward(forward)
`ifdef FWD_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // youngest in-flight writer of rs: 1 = EX (ex_result), 2 = MEM (wb_data), 0 = none
    function automatic int src_of(input bit v, input int rs, input bit used);
        if (!v || !used || rs == 0) return 0;
        for (int k = 0; k < 2; k++) if (hv[k] && hrd[k] == rs) return k + 1;
        return 0;
    endfunction

    function automatic logic [31:0] fwd_exp();
        return m_fsel == 1 ? ex_result : m_fsel == 2 ? wb_data : 32'd0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin hv[k] = 0; hl[k] = 0; hrd[k] = 0; end
        m_nf = 2'b00; m_fsel = 0; m_scount = 0; last_stall = 0;
    endtask

    // one ID cycle; entered and left at posedge+1
    task automatic step(input bit v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        int sa, sb;
        bit ms, wr;
        id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = a; id_rs2 = b;
        ex_result = $urandom; wb_data = $urandom;
        l_op = op; l_rd = rd; l_a = a; l_b = b;
        sa = src_of(v, int'(a), op inside {OP_R, OP_B, OP_I, OP_LD, OP_S, OP_JALR});
        sb = src_of(v, int'(b), op inside {OP_R, OP_B});
        ms = ((sa == 1 || sb == 1) && hl[0]) || (sa != 0 && sb != 0 && sa != sb);
        wr = op inside {OP_R, OP_I, OP_LD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI};
        #1;
        check("stall", {31'd0, stall}, {31'd0, ms});
        @(posedge clk);
        hv[1] = hv[0]; hl[1] = hl[0]; hrd[1] = hrd[0];
        hv[0] = !ms && v && wr && rd != 0; hl[0] = !ms && v && op == OP_LD; hrd[0] = int'(rd);
        m_nf = ms ? 2'b00 : {sa != 0, sb != 0};
        m_fsel = ms ? 0 : sa != 0 ? sa : sb;
        if (ms) m_scount++;
        last_stall = ms;
        #1;
        check("need_forward", {30'd0, need_forward}, {30'd0, m_nf});
        check("forward", forward, fwd_exp());
`ifdef FWD_STATS_EN
        check("stall_count", stall_count, m_scount);
`endif
    endtask

    task automatic flush();
        repeat (2) step(0, OP_SYS, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_nf", {30'd0, need_forward}, 32'd0);
        check("rst_forward", forward, 32'd0);
        reset = 0;
        step(1, OP_R, 5, 1, 2); step(1, OP_R, 6, 5, 3);
        check("add_chain_nf", {30'd0, need_forward}, 32'd2);
        check("add_chain_fwd", forward, ex_result);
        flush();
        step(1, OP_LD, 7, 1, 0); step(1, OP_I, 8, 7, 1);
        check("load_use_stall_nf", {30'd0, need_forward}, 32'd0);
        step(1, OP_I, 8, 7, 1);
        check("load_use_nf", {30'd0, need_forward}, 32'd2);
        check("load_use_fwd", forward, wb_data);
        flush();
        step(1, OP_R, 5, 1, 2); step(1, OP_R, 9, 1, 2); step(1, OP_R, 10, 5, 9);
        step(1, OP_R, 10, 5, 9);
        check("split_nf", {30'd0, need_forward}, 32'd1);
        check("split_fwd", forward, wb_data);
        flush();
        step(1, OP_R, 0, 1, 2); step(1, OP_R, 3, 0, 0);
        check("x0_nf", {30'd0, need_forward}, 32'd0);
        flush();
        step(1, OP_R, 4, 1, 1); step(1, OP_R, 5, 4, 4);
        check("same_src_nf", {30'd0, need_forward}, 32'd3);
        check("same_src_fwd", forward, ex_result);
        flush();
        step(1, OP_LD, 7, 1, 0);
        id_valid = 1; id_opcode = OP_I; id_rd = 8; id_rs1 = 7; id_rs2 = 0;
        #1;
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        #2 reset = 1;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_nf", {30'd0, need_forward}, 32'd0);
`ifdef FWD_STATS_EN
        check("mid_rst_count", stall_count, 32'd0);
`endif
        #1 reset = 0;
        id_valid = 0;
        model_clear();
        @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) begin
            if (last_stall) step(1, l_op, l_rd, l_a, l_b);
            else step($urandom_range(0, 9) != 0, ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
